// File: rtl/mean_calc.sv
// ---------------------------------------------------------------------------
// mean_calc
//
// Reference-level estimator for the drone data link receiver. After a trigger
// (rising edge of data_start, or get_mean_curr while the link is enabled) it
// ignores the link for SETTLE_CYCLES cycles. It then records the folded ADC
// peak in each of 2^LOG2_WINDOWS windows of WINDOW_CYCLES cycles, and publishes
// the truncated mean of those peaks on mean_def.
//
// Ports
//   clk            system clock, all state on the rising edge
//   nrst           asynchronous active-low reset
//   data_start     link enable; 0->1 edge triggers a measurement, low aborts
//   get_mean_curr  measurement request while data_start is high
//   ADC[11:0]      live link sample, unsigned, mid-scale 0x800
//   mean_def[11:0] averaged folded peak, holds the last completed result
//   mean_valid     mean_def holds a result completed since the last trigger
//   busy           high while settling or measuring
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no measurement in progress; mean_def holds the last result
// SETTLE  | deaf time after a trigger, settle counter counting down
// MEASURE | tracking per-window peaks and accumulating them
// ---------------------------------------------------------------------------
module mean_calc #(
    parameter int SETTLE_CYCLES = 500000,
    parameter int WINDOW_CYCLES = 40000,
    parameter int LOG2_WINDOWS  = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        data_start,
    input  logic        get_mean_curr,
    input  logic [11:0] ADC,
    output logic [11:0] mean_def,
    output logic        mean_valid,
    output logic        busy
);

    localparam int CNT_W = 20;
    localparam int ACC_W = 12 + LOG2_WINDOWS;
    // One extra bit keeps the index legal when LOG2_WINDOWS is 0.
    localparam int IDX_W = LOG2_WINDOWS + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD    = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_WIN    = IDX_W'((1 << LOG2_WINDOWS) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE
    } state_t;

    state_t             state;
    logic               data_start_q;
    logic               ds_seen_low;
    logic [CNT_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]   win_cnt;
    logic [IDX_W-1:0]   win_idx;
    logic [11:0]        peak;
    logic [ACC_W-1:0]   acc;

    logic [11:0]        adc_fold;
    logic [11:0]        peak_next;
    logic [ACC_W-1:0]   acc_sum;
    logic               trigger;

    // 0xFFF - ADC is the bitwise complement for a 12-bit value.
    assign adc_fold  = ADC[11] ? ~ADC : ADC;
    assign peak_next = (adc_fold > peak) ? adc_fold : peak;
    assign acc_sum   = acc + ACC_W'(peak_next);

    // An edge only counts once data_start has been seen low since reset, so a
    // link that is already enabled when reset releases stays idle until an
    // explicit request or a fresh 0->1 edge.
    assign trigger = data_start &
                     (get_mean_curr | (~data_start_q & ds_seen_low));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            data_start_q <= 1'b0;
            ds_seen_low  <= 1'b0;
            settle_cnt   <= '0;
            win_cnt      <= '0;
            win_idx      <= '0;
            peak         <= '0;
            acc          <= '0;
            mean_def     <= '0;
            mean_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_start_q <= data_start;
            if (!data_start) begin
                ds_seen_low <= 1'b1;
            end

            if (trigger) begin
                // Any trigger restarts from scratch; a partial result is lost.
                state      <= ST_SETTLE;
                busy       <= 1'b1;
                mean_valid <= 1'b0;
                settle_cnt <= SETTLE_LOAD;
                win_cnt    <= '0;
                win_idx    <= '0;
                peak       <= '0;
                acc        <= '0;
            end else if (!data_start) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                mean_valid <= 1'b0;
                settle_cnt <= '0;
                win_cnt    <= '0;
                win_idx    <= '0;
                peak       <= '0;
                acc        <= '0;
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state   <= ST_MEASURE;
                            win_cnt <= WIN_LOAD;
                            peak    <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end

                    ST_MEASURE: begin
                        if (win_cnt == '0) begin
                            // The current sample still belongs to the closing
                            // window, so peak_next (not peak) is accumulated.
                            if (win_idx == LAST_WIN) begin
                                mean_def   <= acc_sum[ACC_W-1:LOG2_WINDOWS];
                                mean_valid <= 1'b1;
                                busy       <= 1'b0;
                                state      <= ST_IDLE;
                                acc        <= '0;
                                peak       <= '0;
                                win_idx    <= '0;
                            end else begin
                                acc     <= acc_sum;
                                peak    <= '0;
                                win_cnt <= WIN_LOAD;
                                win_idx <= win_idx + 1'b1;
                            end
                        end else begin
                            peak    <= peak_next;
                            win_cnt <= win_cnt - 1'b1;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mean_calc.sv
module tb_mean_calc;

    localparam int S  = 4;
    localparam int W  = 8;
    localparam int LW = 2;
    localparam int LAT = S + W * (1 << LW);   // 36

    logic        clk = 1'b0;
    logic        nrst;
    logic        data_start;
    logic        get_mean_curr;
    logic [11:0] ADC;
    logic [11:0] mean_def;
    logic        mean_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [11:0] val;
        int          edge_n;
    } exp_t;

    exp_t sb[$];

    mean_calc #(
        .SETTLE_CYCLES(S),
        .WINDOW_CYCLES(W),
        .LOG2_WINDOWS (LW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .data_start   (data_start),
        .get_mean_curr(get_mean_curr),
        .ADC          (ADC),
        .mean_def     (mean_def),
        .mean_valid   (mean_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_exp(logic [11:0] v, int e);
        exp_t x;
        x.val    = v;
        x.edge_n = e;
        sb.push_back(x);
    endfunction

    // Monitor: every new result (mean_valid rising) must match the oldest
    // expected entry, both in value and in the edge it appears on.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_valid = 1'b0;
        end else begin
            if (mean_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {20'd0, mean_def}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_mean_def", {20'd0, mean_def}, {20'd0, e.val});
                    chk("sb_result_edge", cyc, e.edge_n);
                    chk("sb_busy_low", {31'd0, busy}, 32'd0);
                end
            end
            prev_valid = mean_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // data_start low for one edge then high; returns the trigger edge.
    task automatic edge_start(output int t);
        data_start = 1'b0;
        tick();
        data_start = 1'b1;
        tick();
        t = cyc;
    endtask

    task automatic run_const(input logic [11:0] adc, input logic [11:0] exp, input string nm);
        int t;
        ADC = adc;
        edge_start(t);
        push_exp(exp, t + LAT);
        chk({nm, "_busy_start"}, {31'd0, busy}, 32'd1);
        chk({nm, "_valid_start"}, {31'd0, mean_valid}, 32'd0);
        repeat (LAT - 1) tick();
        chk({nm, "_busy_last"}, {31'd0, busy}, 32'd1);
        tick();
        chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({nm, "_valid_done"}, {31'd0, mean_valid}, 32'd1);
        chk({nm, "_mean_def"}, {20'd0, mean_def}, {20'd0, exp});
    endtask

    initial begin
        int t;
        int p1;
        int p2;
        logic [11:0] pk [4];
        pk[0] = 12'h100;
        pk[1] = 12'h200;
        pk[2] = 12'h300;
        pk[3] = 12'h401;

        nrst          = 1'b0;
        data_start    = 1'b0;
        get_mean_curr = 1'b0;
        ADC           = 12'h000;
        #1;
        chk("reset_mean_def", {20'd0, mean_def}, 32'd0);
        chk("reset_valid", {31'd0, mean_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        run_const(12'h300, 12'h300, "c300");
        run_const(12'hC00, 12'h3FF, "cC00");
        run_const(12'h800, 12'h7FF, "c800");
        run_const(12'h000, 12'h000, "c000");

        // Peaks on the last cycle of each window; 0x7FF during deaf time
        // would corrupt the mean if it were ever sampled.
        ADC = 12'h7FF;
        edge_start(t);
        push_exp(12'h280, t + LAT);
        for (int i = 1; i <= LAT; i++) begin
            if (i <= S) begin
                ADC = 12'h7FF;
            end else if (((i - S - 1) % W) == W - 1) begin
                ADC = pk[(i - S - 1) / W];
            end else begin
                ADC = 12'h000;
            end
            tick();
        end
        chk("peaks_mean_def", {20'd0, mean_def}, 32'h280);
        chk("peaks_valid", {31'd0, mean_valid}, 32'd1);

        // Retrigger via get_mean_curr mid-run: only the last request completes.
        run_const(12'h300, 12'h300, "pre_rt");
        ADC = 12'h500;
        get_mean_curr = 1'b1;
        tick();
        p1 = cyc;
        get_mean_curr = 1'b0;
        chk("rt_valid_drop", {31'd0, mean_valid}, 32'd0);
        chk("rt_busy", {31'd0, busy}, 32'd1);
        chk("rt_hold_def", {20'd0, mean_def}, 32'h300);
        repeat (9) tick();
        get_mean_curr = 1'b1;
        tick();
        p2 = cyc;
        get_mean_curr = 1'b0;
        chk("rt_gap", p2 - p1, 10);
        push_exp(12'h500, p2 + LAT);
        repeat (LAT - 1) tick();
        chk("rt_no_early_valid", {31'd0, mean_valid}, 32'd0);
        chk("rt_no_early_def", {20'd0, mean_def}, 32'h300);
        tick();
        chk("rt_mean_def", {20'd0, mean_def}, 32'h500);
        chk("rt_valid", {31'd0, mean_valid}, 32'd1);

        // Abort by dropping data_start during MEASURE.
        run_const(12'h300, 12'h300, "pre_ab");
        ADC = 12'h600;
        get_mean_curr = 1'b1;
        tick();
        get_mean_curr = 1'b0;
        repeat (10) tick();
        data_start = 1'b0;
        tick();
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_valid", {31'd0, mean_valid}, 32'd0);
        chk("ab_hold_def", {20'd0, mean_def}, 32'h300);
        repeat (3) tick();
        chk("ab_still_idle", {31'd0, busy}, 32'd0);
        data_start = 1'b1;
        tick();
        t = cyc;
        push_exp(12'h600, t + LAT);
        chk("ab_restart_busy", {31'd0, busy}, 32'd1);
        repeat (LAT - 1) tick();
        chk("ab_restart_busy_last", {31'd0, busy}, 32'd1);
        tick();
        chk("ab_restart_def", {20'd0, mean_def}, 32'h600);

        // Async reset mid-SETTLE with data_start held high.
        get_mean_curr = 1'b1;
        tick();
        get_mean_curr = 1'b0;
        tick();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_async_def", {20'd0, mean_def}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_valid", {31'd0, mean_valid}, 32'd0);
        #2;
        nrst = 1'b1;
        repeat (10) tick();
        chk("rst_stay_idle_busy", {31'd0, busy}, 32'd0);
        chk("rst_stay_idle_valid", {31'd0, mean_valid}, 32'd0);
        ADC = 12'h123;
        get_mean_curr = 1'b1;
        tick();
        t = cyc;
        get_mean_curr = 1'b0;
        push_exp(12'h123, t + LAT);
        chk("rst_req_busy", {31'd0, busy}, 32'd1);
        repeat (LAT) tick();
        chk("rst_req_def", {20'd0, mean_def}, 32'h123);
        chk("rst_req_valid", {31'd0, mean_valid}, 32'd1);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
